// File: rtl/bram_capture_pp_pkg.sv
// Shared definitions for the ping-pong BRAM capture writer.
//  - state_e    : capture FSM state encoding (IDLE, CAPTURE, DONE)
//  - ADDR_W     : width of the BRAM byte address bus
//  - SIZE_W     : width of the completed-window size report
//  - byte_addr(): converts a word index into a BRAM byte address
package bram_capture_pp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam int ADDR_W = 32;
  localparam int SIZE_W = 32;

  // Word index (half select in the MSB, word offset below it) scaled to bytes.
  // A plain multiply keeps non-power-of-2 word widths (e.g. 24-bit) correct.
  function automatic logic [ADDR_W-1:0] byte_addr(
    input logic [ADDR_W-1:0] word_idx,
    input logic [ADDR_W-1:0] bytes_per_word
  );
    return word_idx * bytes_per_word;
  endfunction

endpackage

// File: rtl/bram_capture_pp_edge_det.sv
// Registered rising-edge detector.
//  clk   in  system clock
//  rst_n in  asynchronous reset, active-low (history resets to 0 = inactive)
//  level in  level to watch, already in the clk domain
//  pulse out one-cycle pulse, registered, the cycle after level first reads 1
module bram_capture_pp_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic level_d_r;
  logic pulse_r;

  // Level history and registered edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d_r <= 1'b0;
      pulse_r   <= 1'b0;
    end else begin
      level_d_r <= level;
      pulse_r   <= level & ~level_d_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/bram_capture_pp.sv
// Ping-pong capture writer. Each accepted sync pulse stores a window of valid
// samples into one BRAM half through port A, then flags that half ready; the PS
// releases a half by raising its rdy_w bit. Syncs that cannot be served are
// counted (saturating).
//  clk          in   system clock, forwarded as clkb
//  rst_n        in   asynchronous reset, active-low
//  valid        in   qualifies datos, one sample per cycle
//  sinc         in   window start pulse, active level SINC_POL
//  datos        in   sample data
//  n_samples    in   window length in words, 0 or > DEPTH means DEPTH
//  rdy_w        in   per-half release level from the PS
//  addr         out  BRAM byte address
//  clkb         out  BRAM clock
//  din          out  BRAM write data
//  en_a         out  port A enable
//  we           out  byte write enables (all-ones or all-zeros)
//  rdy          out  half b holds a complete window
//  size_data    out  words in the last completed window
//  busy         out  capture in progress
//  overrun_cnt  out  dropped syncs, saturating
module bram_capture_pp
  import bram_capture_pp_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter bit SINC_POL = 1'b0,
  parameter int CNT_W    = 16,
  localparam int AW      = $clog2(DEPTH),
  localparam int BYTES   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              sinc,
  input  logic [DATA_W-1:0] datos,
  input  logic [AW:0]       n_samples,
  input  logic [1:0]        rdy_w,
  output logic [ADDR_W-1:0] addr,
  output logic              clkb,
  output logic [DATA_W-1:0] din,
  output logic              en_a,
  output logic [BYTES-1:0]  we,
  output logic [1:0]        rdy,
  output logic [SIZE_W-1:0] size_data,
  output logic              busy,
  output logic [CNT_W-1:0]  overrun_cnt
);

  localparam logic [AW:0]      LEN_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW:0]      LEN_ZERO = (AW+1)'(1'b0);
  localparam logic [AW:0]      LEN_ONE  = (AW+1)'(1'b1);
  localparam logic [AW-1:0]    IDX_ZERO = AW'(1'b0);
  localparam logic [AW-1:0]    IDX_ONE  = AW'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e              state_r;
  state_e              next_state_s;
  logic                sync_lvl_s;
  logic                sync_edge_s;
  logic [1:0]          rel_edge_s;
  logic                wp_r;
  logic [AW-1:0]       idx_r;
  logic [AW:0]         len_r;
  logic [AW:0]         len_s;
  logic                last_s;
  logic                accept_s;
  logic                drop_s;
  logic                wr_s;
  logic                done_s;
  logic [1:0]          rdy_nxt_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   din_r;
  logic [BYTES-1:0]    we_r;
  logic                en_a_r;
  logic [1:0]          rdy_r;
  logic [SIZE_W-1:0]   size_r;
  logic                busy_r;
  logic [CNT_W-1:0]    ovr_r;

  assign sync_lvl_s = (sinc == SINC_POL);

  bram_capture_pp_edge_det u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .level (sync_lvl_s),
    .pulse (sync_edge_s)
  );

  bram_capture_pp_edge_det u_rel_edge0 (
    .clk   (clk),
    .rst_n (rst_n),
    .level (rdy_w[0]),
    .pulse (rel_edge_s[0])
  );

  bram_capture_pp_edge_det u_rel_edge1 (
    .clk   (clk),
    .rst_n (rst_n),
    .level (rdy_w[1]),
    .pulse (rel_edge_s[1])
  );

  // Window length to latch on acceptance: 0 or anything beyond one half means a full half.
  always_comb begin
    len_s = LEN_MAX;
    if ((n_samples == LEN_ZERO) || (n_samples > LEN_MAX)) begin
      len_s = LEN_MAX;
    end else begin
      len_s = n_samples;
    end
  end

  assign last_s = ({1'b0, idx_r} == (len_r - LEN_ONE));

  // A release clears its half; a finishing window sets its own half. A release
  // aimed at the finishing half cannot coincide with a set rdy bit, so order is moot.
  assign rdy_nxt_s = (rdy_r & ~rel_edge_s) | (done_s ? (2'b01 << wp_r) : 2'b00);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next state and per-cycle actions.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    drop_s       = 1'b0;
    wr_s         = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sync_edge_s) begin
          // A release landing on the target half this same cycle frees it in time.
          if (!rdy_r[wp_r] || rel_edge_s[wp_r]) begin
            accept_s     = 1'b1;
            next_state_s = ST_CAPTURE;
          end else begin
            drop_s       = 1'b1;
            next_state_s = ST_IDLE;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        drop_s = sync_edge_s;
        if (valid) begin
          wr_s = 1'b1;
          if (last_s) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_CAPTURE;
          end
        end else begin
          next_state_s = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        drop_s       = sync_edge_s;
        done_s       = 1'b1;
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Write pointer, word index and latched window length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_r  <= 1'b0;
      idx_r <= IDX_ZERO;
      len_r <= LEN_ZERO;
    end else begin
      if (accept_s) begin
        idx_r <= IDX_ZERO;
        len_r <= len_s;
      end else if (wr_s && !last_s) begin
        // Holding on the last word keeps idx inside the half.
        idx_r <= idx_r + IDX_ONE;
      end
      if (done_s) begin
        wp_r <= ~wp_r;
      end
    end
  end

  // Registered BRAM port A; addr and din hold across gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= {ADDR_W{1'b0}};
      din_r  <= {DATA_W{1'b0}};
      we_r   <= {BYTES{1'b0}};
      en_a_r <= 1'b0;
    end else if (wr_s) begin
      addr_r <= byte_addr(ADDR_W'({wp_r, idx_r}), ADDR_W'(BYTES));
      din_r  <= datos;
      we_r   <= {BYTES{1'b1}};
      en_a_r <= 1'b1;
    end else begin
      we_r   <= {BYTES{1'b0}};
      en_a_r <= 1'b0;
    end
  end

  // Ready flags, window size, busy and saturating overrun count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_r  <= 2'b00;
      size_r <= {SIZE_W{1'b0}};
      busy_r <= 1'b0;
      ovr_r  <= {CNT_W{1'b0}};
    end else begin
      rdy_r  <= rdy_nxt_s;
      busy_r <= (next_state_s == ST_CAPTURE);
      if (done_s) begin
        size_r <= SIZE_W'(len_r);
      end
      if (drop_s && (ovr_r != CNT_MAX)) begin
        ovr_r <= ovr_r + CNT_ONE;
      end
    end
  end

  assign clkb        = clk;
  assign addr        = addr_r;
  assign din         = din_r;
  assign we          = we_r;
  assign en_a        = en_a_r;
  assign rdy         = rdy_r;
  assign size_data   = size_r;
  assign busy        = busy_r;
  assign overrun_cnt = ovr_r;

endmodule
